// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter.
// Contents: the default parameter values, the source identifiers used by the
// round-robin priority pointer, and the grant-selection helper function.
package wb_arbiter_pkg;

    localparam int DEF_NUM_PHYS_REGS = 64;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_DATA_WIDTH    = 32;

    // Values of the priority pointer: the source that wins the next contended cycle.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Grant vector: bit 0 = source A, bit 1 = source B. At most one bit is set.
    // The priority pointer only decides the winner when both heads are present.
    function automatic logic [1:0] arb_grant(input logic has_a, input logic has_b,
                                             input logic prio);
        logic [1:0] g;
        g = 2'b00;
        if (has_a && has_b) begin
            if (prio == SRC_A) begin
                g = 2'b01;
            end else begin
                g = 2'b10;
            end
        end else if (has_a) begin
            g = 2'b01;
        end else if (has_b) begin
            g = 2'b10;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result buffer for the write-back arbiter.
// Ports: clk/rst_n (async active-low), flush (sync clear), push/wdata (enqueue),
// pop/rdata (dequeue, rdata shows the head combinationally), full, empty, count.
// A push while full and a pop while empty are ignored.
module wb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 38,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: producer side of the physical register file write and
// busy-clear ports. Results from source A (ALU) and source B (MEM) are buffered
// in one wb_fifo each; at most one is written per cycle, chosen round-robin.
// Ports: CLK, RESET (async active-low), A_/B_ Valid/Reg/Data inputs with Ready
// outputs, Flush_IN (sync, highest priority), registered write port
// (RegWrite_OUT/DataWrite_OUT/Write_OUT), busy-clear port (FreeReg_OUT/SetFree_OUT,
// mirrors the write port) and Pending_OUT (total buffered entries).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
    parameter  int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
    localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS),
    localparam int CNT_W         = $clog2(FIFO_DEPTH + 1),
    localparam int PEND_W        = $clog2(2 * FIFO_DEPTH + 1),
    localparam int ENT_W         = LOG_PHYS + DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  A_Valid_IN,
    input  logic [LOG_PHYS-1:0]   A_Reg_IN,
    input  logic [DATA_WIDTH-1:0] A_Data_IN,
    output logic                  A_Ready_OUT,
    input  logic                  B_Valid_IN,
    input  logic [LOG_PHYS-1:0]   B_Reg_IN,
    input  logic [DATA_WIDTH-1:0] B_Data_IN,
    output logic                  B_Ready_OUT,
    input  logic                  Flush_IN,
    output logic [LOG_PHYS-1:0]   RegWrite_OUT,
    output logic [DATA_WIDTH-1:0] DataWrite_OUT,
    output logic                  Write_OUT,
    output logic [LOG_PHYS-1:0]   FreeReg_OUT,
    output logic                  SetFree_OUT,
    output logic [PEND_W-1:0]     Pending_OUT
);

    logic                  full_a_s, empty_a_s, full_b_s, empty_b_s;
    logic [CNT_W-1:0]      count_a_s, count_b_s, cnt_a_nxt_s, cnt_b_nxt_s;
    logic [ENT_W-1:0]      head_a_s, head_b_s, head_sel_s;
    logic                  push_a_s, push_b_s, pop_a_s, pop_b_s, flip_s;
    logic [1:0]            grant_s;
    logic [PEND_W-1:0]     pend_nxt_s;

    logic                  prio_r;
    logic                  write_r;
    logic [LOG_PHYS-1:0]   reg_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [PEND_W-1:0]     pend_r;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo_a (
        .clk   (CLK),
        .rst_n (RESET),
        .flush (Flush_IN),
        .push  (push_a_s),
        .pop   (pop_a_s),
        .wdata ({A_Reg_IN, A_Data_IN}),
        .rdata (head_a_s),
        .full  (full_a_s),
        .empty (empty_a_s),
        .count (count_a_s)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo_b (
        .clk   (CLK),
        .rst_n (RESET),
        .flush (Flush_IN),
        .push  (push_b_s),
        .pop   (pop_b_s),
        .wdata ({B_Reg_IN, B_Data_IN}),
        .rdata (head_b_s),
        .full  (full_b_s),
        .empty (empty_b_s),
        .count (count_b_s)
    );

    // Ready depends on registered occupancy only: a full FIFO refuses even while draining.
    assign A_Ready_OUT = !full_a_s;
    assign B_Ready_OUT = !full_b_s;

    // Grant, enqueue qualification and next occupancy; flush suppresses all traffic.
    always_comb begin
        grant_s    = 2'b00;
        push_a_s   = 1'b0;
        push_b_s   = 1'b0;
        flip_s     = 1'b0;
        head_sel_s = head_a_s;
        if (Flush_IN) begin
            grant_s  = 2'b00;
            push_a_s = 1'b0;
            push_b_s = 1'b0;
            flip_s   = 1'b0;
        end else begin
            grant_s  = arb_grant(!empty_a_s, !empty_b_s, prio_r);
            push_a_s = A_Valid_IN && !full_a_s;
            push_b_s = B_Valid_IN && !full_b_s;
            // The pointer only moves when it actually resolved a conflict.
            flip_s   = !empty_a_s && !empty_b_s;
        end
        pop_a_s = grant_s[0];
        pop_b_s = grant_s[1];
        if (grant_s[1]) begin
            head_sel_s = head_b_s;
        end else begin
            head_sel_s = head_a_s;
        end
        if (Flush_IN) begin
            cnt_a_nxt_s = {CNT_W{1'b0}};
            cnt_b_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_a_nxt_s = count_a_s + CNT_W'(push_a_s) - CNT_W'(pop_a_s);
            cnt_b_nxt_s = count_b_s + CNT_W'(push_b_s) - CNT_W'(pop_b_s);
        end
        pend_nxt_s = PEND_W'(cnt_a_nxt_s) + PEND_W'(cnt_b_nxt_s);
    end

    // Output stage, priority pointer and pending count; address/data hold when idle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prio_r  <= SRC_A;
            write_r <= 1'b0;
            reg_r   <= {LOG_PHYS{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            pend_r  <= {PEND_W{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
            if (flip_s) begin
                prio_r <= !prio_r;
            end
            if (grant_s != 2'b00) begin
                write_r <= 1'b1;
                reg_r   <= head_sel_s[ENT_W-1:DATA_WIDTH];
                data_r  <= head_sel_s[DATA_WIDTH-1:0];
            end else begin
                write_r <= 1'b0;
            end
        end
    end

    assign Write_OUT     = write_r;
    assign SetFree_OUT   = write_r;
    assign RegWrite_OUT  = reg_r;
    assign FreeReg_OUT   = reg_r;
    assign DataWrite_OUT = data_r;
    assign Pending_OUT   = pend_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int LP    = 6;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, flush;
    logic [LP-1:0] a_reg, b_reg;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic [LP-1:0] reg_w, free_reg;
    logic [DW-1:0] data_w;
    logic          write, set_free;
    logic [PW-1:0] pending;

    wb_arbiter dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .A_Valid_IN   (a_valid),
        .A_Reg_IN     (a_reg),
        .A_Data_IN    (a_data),
        .A_Ready_OUT  (a_ready),
        .B_Valid_IN   (b_valid),
        .B_Reg_IN     (b_reg),
        .B_Data_IN    (b_data),
        .B_Ready_OUT  (b_ready),
        .Flush_IN     (flush),
        .RegWrite_OUT (reg_w),
        .DataWrite_OUT(data_w),
        .Write_OUT    (write),
        .FreeReg_OUT  (free_reg),
        .SetFree_OUT  (set_free),
        .Pending_OUT  (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LP-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model state
    ent_t          qa[$];
    ent_t          qb[$];
    bit            prio_b;
    logic          exp_write;
    logic [LP-1:0] exp_reg;
    logic [DW-1:0] exp_data;
    logic [PW-1:0] exp_pend;

    int n_cmp = 0;
    int n_err = 0;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        prio_b    = 1'b0;
        exp_write = 1'b0;
        exp_reg   = '0;
        exp_data  = '0;
        exp_pend  = '0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then
    // move the DUT across the rising edge and stop at the following falling edge.
    task automatic tick();
        ent_t e;
        bit acc_a, acc_b, has_a, has_b, take_a, take_b;
        acc_a = a_valid && (qa.size() != DEPTH);
        acc_b = b_valid && (qb.size() != DEPTH);
        if (flush) begin
            qa.delete();
            qb.delete();
            exp_write = 1'b0;
        end else begin
            has_a  = qa.size() != 0;
            has_b  = qb.size() != 0;
            take_a = has_a && (!has_b || !prio_b);
            take_b = has_b && !take_a;
            if (has_a && has_b) prio_b = !prio_b;
            e = '0;
            if (take_a) e = qa.pop_front();
            else if (take_b) e = qb.pop_front();
            exp_write = take_a || take_b;
            if (exp_write) begin
                exp_reg  = e.r;
                exp_data = e.d;
            end
            if (acc_a) begin e.r = a_reg; e.d = a_data; qa.push_back(e); end
            if (acc_b) begin e.r = b_reg; e.d = b_data; qb.push_back(e); end
        end
        exp_pend = PW'(qa.size() + qb.size());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0; flush = 1'b0;
        a_reg = 6'd7; a_data = 32'h1234_5678; b_reg = '0; b_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (write !== 1'b0 || set_free !== 1'b0) begin n_err++; $display("FAIL reset_write: got %0b/%0b want 0", write, set_free); end
        n_cmp++; if (pending !== 4'd0) begin n_err++; $display("FAIL reset_pending: got %0d want 0", pending); end
        n_cmp++; if (reg_w !== 6'd0 || data_w !== 32'd0 || free_reg !== 6'd0) begin n_err++; $display("FAIL reset_addr: got %0d/%h/%0d want 0", reg_w, data_w, free_reg); end
        rst_n = 1'b1; a_valid = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b/%0b want 1/1", a_ready, b_ready); end
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_reg = 6'd5; a_data = 32'hDEAD_BEEF;
        tick();
        a_valid = 1'b0;
        n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL single_early: got %0b want 0", write); end
        n_cmp++; if (pending !== 4'd1) begin n_err++; $display("FAIL single_pend1: got %0d want 1", pending); end
        tick();
        n_cmp++; if (write !== 1'b1 || set_free !== 1'b1) begin n_err++; $display("FAIL single_write: got %0b/%0b want 1/1", write, set_free); end
        n_cmp++; if (reg_w !== 6'd5 || free_reg !== 6'd5) begin n_err++; $display("FAIL single_reg: got %0d/%0d want 5/5", reg_w, free_reg); end
        n_cmp++; if (data_w !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", data_w); end
        tick();
        n_cmp++; if (write !== 1'b0 || set_free !== 1'b0) begin n_err++; $display("FAIL single_once: got %0b/%0b want 0/0", write, set_free); end
        n_cmp++; if (reg_w !== 6'd5 || data_w !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_hold: got %0d/%h want 5/deadbeef", reg_w, data_w); end
    endtask

    task automatic test_contention();
        int got[$];
        int first, last;
        int exp3[6] = '{1, 9, 2, 10, 3, 11};
        first = -1; last = -1;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_reg = LP'(1 + k); a_data = $urandom;
            b_valid = 1'b1; b_reg = LP'(9 + k); b_data = $urandom;
            tick();
            if (write) begin got.push_back(int'(reg_w)); if (first < 0) first = k; last = k; end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 3; k < 12; k++) begin
            tick();
            if (write) begin got.push_back(int'(reg_w)); if (first < 0) first = k; last = k; end
            n_cmp++; if (write !== exp_write || data_w !== exp_data) begin n_err++; $display("FAIL cont_model cyc %0d: got %0b/%h want %0b/%h", k, write, data_w, exp_write, exp_data); end
        end
        n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL cont_count: got %0d writes want 6", got.size()); end
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            n_cmp++; if (got[k] != exp3[k]) begin n_err++; $display("FAIL cont_order idx %0d: got %0d want %0d", k, got[k], exp3[k]); end
        end
        n_cmp++; if (last - first != 5) begin n_err++; $display("FAIL cont_back_to_back: got span %0d want 5", last - first); end
    endtask

    task automatic test_full();
        int guard;
        int seen63;
        guard = 0; seen63 = 0;
        while (a_ready === 1'b1 && guard < 30) begin
            a_valid = 1'b1; a_reg = LP'($urandom_range(0, 62)); a_data = $urandom;
            b_valid = 1'b1; b_reg = LP'($urandom_range(0, 62)); b_data = $urandom;
            tick();
            guard++;
            n_cmp++; if (write !== exp_write || reg_w !== exp_reg || pending !== exp_pend) begin n_err++; $display("FAIL full_fill cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", guard, write, reg_w, pending, exp_write, exp_reg, exp_pend); end
        end
        n_cmp++; if (a_ready !== 1'b0 || qa.size() != DEPTH) begin n_err++; $display("FAIL full_ready: got ready %0b model size %0d want 0/%0d", a_ready, qa.size(), DEPTH); end
        // Extra offer while full must not be captured.
        a_valid = 1'b1; a_reg = 6'd63; a_data = 32'hFFFF_0063; b_valid = 1'b0;
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            n_cmp++; if (write !== exp_write || reg_w !== exp_reg || data_w !== exp_data || pending !== exp_pend) begin n_err++; $display("FAIL full_drain cyc %0d: got %0b/%0d/%h/%0d want %0b/%0d/%h/%0d", k, write, reg_w, data_w, pending, exp_write, exp_reg, exp_data, exp_pend); end
            if (write && reg_w == 6'd63) seen63++;
            tick();
        end
        n_cmp++; if (seen63 != 0) begin n_err++; $display("FAIL full_no_capture: got %0d writes of reg 63 want 0", seen63); end
        n_cmp++; if (pending !== 4'd0) begin n_err++; $display("FAIL full_empty: got %0d want 0", pending); end
    endtask

    task automatic test_flush();
        int guard;
        guard = 0;
        while (pending !== 4'd6 && guard < 12) begin
            a_valid = 1'b1; a_reg = LP'($urandom_range(0, 62)); a_data = $urandom;
            b_valid = 1'b1; b_reg = LP'($urandom_range(0, 62)); b_data = $urandom;
            tick();
            guard++;
        end
        n_cmp++; if (pending !== 4'd6 || exp_pend != 4'd6) begin n_err++; $display("FAIL flush_prefill: got %0d model %0d want 6", pending, exp_pend); end
        flush = 1'b1; a_valid = 1'b1; b_valid = 1'b0;
        tick();
        flush = 1'b0; a_valid = 1'b0;
        n_cmp++; if (pending !== 4'd0) begin n_err++; $display("FAIL flush_pending: got %0d want 0", pending); end
        n_cmp++; if (write !== 1'b0 || set_free !== 1'b0) begin n_err++; $display("FAIL flush_write: got %0b/%0b want 0/0", write, set_free); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (write !== 1'b0 || pending !== 4'd0) begin n_err++; $display("FAIL flush_stale cyc %0d: got %0b/%0d want 0/0", k, write, pending); end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_reg = LP'($urandom_range(0, 62)); a_data = $urandom;
            b_valid = 1'b1; b_reg = LP'($urandom_range(0, 62)); b_data = $urandom;
            tick();
        end
        n_cmp++; if (write !== 1'b1 || pending === 4'd0) begin n_err++; $display("FAIL areset_pre: got %0b/%0d want 1/nonzero", write, pending); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (write !== 1'b0 || set_free !== 1'b0 || pending !== 4'd0) begin n_err++; $display("FAIL areset_immediate: got %0b/%0b/%0d want 0/0/0", write, set_free, pending); end
        n_cmp++; if (reg_w !== 6'd0 || data_w !== 32'd0) begin n_err++; $display("FAIL areset_addr: got %0d/%h want 0/0", reg_w, data_w); end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (write !== 1'b0 || pending !== 4'd0) begin n_err++; $display("FAIL areset_stale cyc %0d: got %0b/%0d want 0/0", k, write, pending); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_valid = ($urandom_range(0, 3) != 0); a_reg = LP'($urandom); a_data = $urandom;
            b_valid = ($urandom_range(0, 2) != 0); b_reg = LP'($urandom); b_data = $urandom;
            flush   = ($urandom_range(0, 29) == 0);
            tick();
            n_cmp++; if (write !== exp_write || set_free !== exp_write) begin n_err++; $display("FAIL rnd_write cyc %0d: got %0b/%0b want %0b", i, write, set_free, exp_write); end
            n_cmp++; if (reg_w !== exp_reg || free_reg !== exp_reg || data_w !== exp_data) begin n_err++; $display("FAIL rnd_data cyc %0d: got %0d/%0d/%h want %0d/%h", i, reg_w, free_reg, data_w, exp_reg, exp_data); end
            n_cmp++; if (pending !== exp_pend) begin n_err++; $display("FAIL rnd_pending cyc %0d: got %0d want %0d", i, pending, exp_pend); end
            n_cmp++; if (a_ready !== (qa.size() != DEPTH) || b_ready !== (qb.size() != DEPTH)) begin n_err++; $display("FAIL rnd_ready cyc %0d: got %0b/%0b want %0b/%0b", i, a_ready, b_ready, qa.size() != DEPTH, qb.size() != DEPTH); end
        end
        a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
